vend_credit_ctrl: RTL and testbench
===================================

Name: vend_credit_ctrl

Overview:
- Parametrised successor to the candy-machine accumulator datapath.
- Accumulates coin credit, vends one of N products at per-product prices, and returns change.
- Change is returned greedily, one coin per valid/ready handshake.
- Sits between the coin acceptor/selector front-end and the dispenser/change-hopper drivers.

Parameters:
- W, 10, credit/price width in bits (credit range 0..2^W-1).
- N_PROD, 4, number of products (>=1).
- PRICES, {10'd125,10'd100,10'd65,10'd80}, packed N_PROD*W vector; product i price = PRICES[i*W +: W].
- MAX_CREDIT, 200, credit ceiling; must be < 2^W.
- COIN1/COIN2/COIN3, 5/10/25, values of coin codes 01/10/11. All prices and MAX_CREDIT are multiples of COIN1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle strobe, coin inserted
- coin_sel  in  2  coin code (00 = no value)
- coin_reject  out  1  one-cycle pulse, coin refused (route to return chute)
- prod_req  in  1  one-cycle strobe, vend request
- prod_sel  in  $clog2(N_PROD) (min 1)  requested product index
- cancel  in  1  one-cycle strobe, refund all credit
- dispense  out  1  one-cycle pulse, release product
- dispense_id  out  $clog2(N_PROD)  product index, valid with dispense
- insufficient  out  1  one-cycle pulse, request refused (credit < price or prod_sel >= N_PROD)
- chg_valid  out  1  change coin offered
- chg_sel  out  2  change coin code, stable while chg_valid & !chg_ready
- chg_ready  in  1  hopper accepts coin
- credit  out  W  current credit
- busy  out  1  high in any state other than IDLE

Behaviour:
Reset:
- Reset is asynchronous; credit=0, state=IDLE.
- All pulses, chg_valid, busy and dispense_id are 0.
- Reset mid-CHANGE abandons the remaining change; credit is cleared.

States: IDLE, VEND, CHANGE.

IDLE:
- Priority is cancel > prod_req > coin_valid.
- Lower-priority strobes in the same cycle are dropped. A dropped coin_valid with coin_sel != 00 pulses coin_reject next cycle.
- coin_valid, coin_sel != 00: if credit + value <= MAX_CREDIT, credit += value next edge; otherwise coin_reject pulses one cycle later and credit is unchanged.
- coin_sel == 00: ignored, no reject.
- prod_req with valid prod_sel and credit >= price: go to VEND. Latch prod_sel; credit -= price at the same edge.
- prod_req otherwise: insufficient pulses one cycle later; state and credit are unchanged.
- cancel: go to CHANGE if credit != 0; otherwise ignored.

VEND (exactly 1 cycle):
- dispense=1 and dispense_id=latched index.
- Next state is CHANGE if credit != 0, else IDLE.
- Request-to-dispense latency is 1 cycle.

CHANGE:
- chg_valid=1; chg_sel = largest coin with value <= credit (greedy 25/10/5 for defaults).
- On chg_valid & chg_ready: credit -= coin value at that edge, and chg_sel is re-evaluated.
- When credit reaches 0, go to IDLE with chg_valid=0 in the following cycle.
- If 0 < credit < COIN1 (illegal parameterisation), credit is cleared and the block returns to IDLE.
- coin_valid is rejected (coin_reject pulse); prod_req and cancel are ignored.

Arithmetic:
- Additions are computed at W+1 bits before the MAX_CREDIT compare; no wrap-around is possible.
- Subtractions occur only when the operand is <= credit.

Decomposition:
- Package vend_pkg holds: state enum (IDLE/VEND/CHANGE), coin code constants (COIN_NONE/C1/C2/C3), and a function coin_value(code).
- Sub-module vend_change_sel: combinational greedy selector (credit -> chg_sel, value). Instantiated once.

Test Plan:
1. Coins 25,25,25,10 (4 strobes) -> credit 85. prod_req sel=0 -> dispense pulse with id 0, credit 5, then chg_valid with sel 01; chg_ready -> credit 0, busy=0.
2. Credit 50, prod_req sel=2 (price 100) -> insufficient pulse, credit stays 50, no dispense.
3. Credit 190, insert 25 -> coin_reject pulse, credit 190. Insert 10 -> credit 200.
4. Credit 65 (25+25+10+5), cancel, chg_ready held low 3 cycles, then high -> chg_sel 11 stable while stalled; sequence 11,11,10,01; credit 40,15,5,0.
5. Same cycle coin_valid(25) + prod_req(sel 1) at credit 80 -> VEND product 1, credit 15, coin_reject pulse. During CHANGE, insert coin -> coin_reject.
6. Assert rst mid-CHANGE at credit 35 -> credit 0, chg_valid 0, IDLE immediately (async). After release, a 5 coin -> credit 5.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, coin codes and coin valuation for the credit controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_C1 = 2'b01;
  localparam logic [1:0] COIN_C2 = 2'b10;
  localparam logic [1:0] COIN_C3 = 2'b11;
  function automatic int coin_value(input logic [1:0] code, input int c1, input int c2, input int c3);
    return code == COIN_C3 ? c3 : code == COIN_C2 ? c2 : code == COIN_C1 ? c1 : 0;
  endfunction
endpackage

// File: rtl/vend_credit_ctrl_if.sv
// vend_credit_ctrl_if: coin, vend and change-hopper signals between front-end and controller
interface vend_credit_ctrl_if #(parameter int W = 10, parameter int PW = 2);
  logic coin_valid;
  logic [1:0] coin_sel;
  logic coin_reject;
  logic prod_req;
  logic [PW-1:0] prod_sel;
  logic cancel;
  logic dispense;
  logic [PW-1:0] dispense_id;
  logic insufficient;
  logic chg_valid;
  logic [1:0] chg_sel;
  logic chg_ready;
  logic [W-1:0] credit;
  logic busy;
  modport slave (
    input coin_valid, coin_sel, prod_req, prod_sel, cancel, chg_ready,
    output coin_reject, dispense, dispense_id, insufficient, chg_valid, chg_sel, credit, busy
  );
  modport master (
    output coin_valid, coin_sel, prod_req, prod_sel, cancel, chg_ready,
    input coin_reject, dispense, dispense_id, insufficient, chg_valid, chg_sel, credit, busy
  );
endinterface

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy largest-coin-not-exceeding-credit selector for change return
module vend_change_sel import vend_pkg::*; #(
  parameter int W = 10,
  parameter int COIN1 = 5,
  parameter int COIN2 = 10,
  parameter int COIN3 = 25
) (
  input  logic [W-1:0] credit,
  output logic [1:0]   sel,
  output logic [W-1:0] val
);
  always_comb begin
    sel = credit >= W'(COIN3) ? COIN_C3 : credit >= W'(COIN2) ? COIN_C2 : credit >= W'(COIN1) ? COIN_C1 : COIN_NONE;
    val = W'(coin_value(sel, COIN1, COIN2, COIN3));
  end
endmodule

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin credit accumulator with per-product vend and greedy change return
module vend_credit_ctrl import vend_pkg::*; #(
  parameter int W = 10,
  parameter int N_PROD = 4,
  parameter logic [N_PROD*W-1:0] PRICES = {10'd125, 10'd100, 10'd65, 10'd80},
  parameter int MAX_CREDIT = 200,
  parameter int COIN1 = 5,
  parameter int COIN2 = 10,
  parameter int COIN3 = 25
) (
  input logic clk,
  input logic rst,
  vend_credit_ctrl_if.slave bus
);
  localparam int PW = N_PROD > 1 ? $clog2(N_PROD) : 1;
  localparam int WP1 = W + 1;
  state_t state;
  logic [W-1:0] credit, price, chg_val;
  logic [W:0] sum;
  logic [1:0] chg_sel;
  logic [PW-1:0] dispense_id;
  logic coin_live, pvalid, coin_reject, insufficient, dispense, chg_valid, busy;
  vend_change_sel #(.W(W), .COIN1(COIN1), .COIN2(COIN2), .COIN3(COIN3)) u_sel (
    .credit(credit), .sel(chg_sel), .val(chg_val)
  );
  assign coin_live = bus.coin_valid && bus.coin_sel != COIN_NONE;
  assign pvalid = int'(bus.prod_sel) < N_PROD;
  assign price = pvalid ? PRICES[bus.prod_sel*W +: W] : '0;
  assign sum = {1'b0, credit} + WP1'(coin_value(bus.coin_sel, COIN1, COIN2, COIN3));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      dispense_id <= '0;
      coin_reject <= 1'b0;
      insufficient <= 1'b0;
      dispense <= 1'b0;
      chg_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      insufficient <= 1'b0;
      dispense <= 1'b0;
      case (state)
        IDLE:
          if (bus.cancel) begin
            coin_reject <= coin_live;
            if (credit != '0) begin
              state <= CHANGE;
              chg_valid <= 1'b1;
              busy <= 1'b1;
            end
          end else if (bus.prod_req) begin
            coin_reject <= coin_live;
            if (pvalid && credit >= price) begin
              state <= VEND;
              credit <= credit - price;
              dispense_id <= bus.prod_sel;
              dispense <= 1'b1;
              busy <= 1'b1;
            end else insufficient <= 1'b1;
          end else if (coin_live) begin
            if (sum <= WP1'(MAX_CREDIT)) credit <= sum[W-1:0];
            else coin_reject <= 1'b1;
          end
        VEND: begin
          coin_reject <= coin_live;
          state <= credit != '0 ? CHANGE : IDLE;
          chg_valid <= credit != '0;
          busy <= credit != '0;
        end
        CHANGE: begin
          coin_reject <= coin_live;
          // a residue below the smallest coin cannot be paid out, so it is forfeited
          if (chg_val == '0 || (bus.chg_ready && credit == chg_val)) begin
            credit <= '0;
            state <= IDLE;
            chg_valid <= 1'b0;
            busy <= 1'b0;
          end else if (bus.chg_ready) credit <= credit - chg_val;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.coin_reject = coin_reject;
  assign bus.insufficient = insufficient;
  assign bus.dispense = dispense;
  assign bus.dispense_id = dispense_id;
  assign bus.chg_valid = chg_valid;
  assign bus.chg_sel = chg_sel;
  assign bus.credit = credit;
  assign bus.busy = busy;
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: directed vectors with hand-computed expectations for vend_credit_ctrl
module tb_vend_credit_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  vend_credit_ctrl_if #(.W(10), .PW(2)) bus ();
  vend_credit_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic coin(input logic [1:0] sel);
    bus.coin_valid = 1'b1;
    bus.coin_sel = sel;
    @(negedge clk);
    bus.coin_valid = 1'b0;
    bus.coin_sel = 2'b00;
  endtask
  task automatic req(input logic [1:0] sel);
    bus.prod_req = 1'b1;
    bus.prod_sel = sel;
    @(negedge clk);
    bus.prod_req = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.chg_ready = 1'b1;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.chg_ready = 1'b0;
    chk("drain_credit", int'(bus.credit), 0);
    chk("drain_busy", int'(bus.busy), 0);
  endtask
  initial begin
    int exp_sel[4] = '{3, 3, 2, 1};
    int exp_cr[4] = '{40, 15, 5, 0};
    bus.coin_valid = 1'b0;
    bus.coin_sel = 2'b00;
    bus.prod_req = 1'b0;
    bus.prod_sel = 2'd0;
    bus.cancel = 1'b0;
    bus.chg_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_chg_valid", int'(bus.chg_valid), 0);
    chk("rst_dispense", int'(bus.dispense), 0);
    chk("rst_dispense_id", int'(bus.dispense_id), 0);
    rst = 1'b0;
    @(negedge clk);
    // vend product 0 (80) from 85, then one 5 coin of change
    coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b10);
    chk("t1_credit85", int'(bus.credit), 85);
    req(2'd0);
    chk("t1_dispense", int'(bus.dispense), 1);
    chk("t1_dispense_id", int'(bus.dispense_id), 0);
    chk("t1_credit5", int'(bus.credit), 5);
    chk("t1_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("t1_dispense_off", int'(bus.dispense), 0);
    chk("t1_chg_valid", int'(bus.chg_valid), 1);
    chk("t1_chg_sel", int'(bus.chg_sel), 1);
    bus.chg_ready = 1'b1;
    @(negedge clk);
    bus.chg_ready = 1'b0;
    chk("t1_credit0", int'(bus.credit), 0);
    chk("t1_chg_valid_off", int'(bus.chg_valid), 0);
    chk("t1_busy_off", int'(bus.busy), 0);
    // insufficient credit for product 2 (100), plus a no-value coin code
    coin(2'b11); coin(2'b11); coin(2'b00);
    chk("t2_null_coin_reject", int'(bus.coin_reject), 0);
    chk("t2_credit50", int'(bus.credit), 50);
    req(2'd2);
    chk("t2_insufficient", int'(bus.insufficient), 1);
    chk("t2_no_dispense", int'(bus.dispense), 0);
    chk("t2_credit_kept", int'(bus.credit), 50);
    chk("t2_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("t2_insufficient_off", int'(bus.insufficient), 0);
    drain();
    // ceiling: 190 + 25 refused, 190 + 10 reaches exactly 200
    repeat (7) coin(2'b11);
    coin(2'b10); coin(2'b01);
    chk("t3_credit190", int'(bus.credit), 190);
    coin(2'b11);
    chk("t3_reject", int'(bus.coin_reject), 1);
    chk("t3_credit_kept", int'(bus.credit), 190);
    coin(2'b10);
    chk("t3_reject_off", int'(bus.coin_reject), 0);
    chk("t3_credit200", int'(bus.credit), 200);
    drain();
    // refund 65 with a 3-cycle hopper stall
    coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b01);
    chk("t4_credit65", int'(bus.credit), 65);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_valid", int'(bus.chg_valid), 1);
      chk("t4_stall_sel", int'(bus.chg_sel), 3);
      chk("t4_stall_credit", int'(bus.credit), 65);
      @(negedge clk);
    end
    bus.chg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_seq_sel", int'(bus.chg_sel), exp_sel[i]);
      @(negedge clk);
      chk("t4_seq_credit", int'(bus.credit), exp_cr[i]);
    end
    bus.chg_ready = 1'b0;
    chk("t4_chg_valid_off", int'(bus.chg_valid), 0);
    chk("t4_busy_off", int'(bus.busy), 0);
    // simultaneous coin and vend: vend wins, coin refused
    coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b01);
    chk("t5_credit80", int'(bus.credit), 80);
    bus.coin_valid = 1'b1;
    bus.coin_sel = 2'b11;
    req(2'd1);
    bus.coin_valid = 1'b0;
    bus.coin_sel = 2'b00;
    chk("t5_dispense", int'(bus.dispense), 1);
    chk("t5_dispense_id", int'(bus.dispense_id), 1);
    chk("t5_credit15", int'(bus.credit), 15);
    chk("t5_reject", int'(bus.coin_reject), 1);
    @(negedge clk);
    chk("t5_chg_valid", int'(bus.chg_valid), 1);
    chk("t5_chg_sel", int'(bus.chg_sel), 2);
    coin(2'b10);
    chk("t5_change_reject", int'(bus.coin_reject), 1);
    chk("t5_change_credit", int'(bus.credit), 15);
    drain();
    // asynchronous reset in the middle of a refund
    coin(2'b11); coin(2'b10);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("t6_chg_valid", int'(bus.chg_valid), 1);
    chk("t6_credit35", int'(bus.credit), 35);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_credit", int'(bus.credit), 0);
    chk("t6_async_chg_valid", int'(bus.chg_valid), 0);
    chk("t6_async_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    coin(2'b01);
    chk("t6_credit5", int'(bus.credit), 5);
    chk("t6_idle", int'(bus.chg_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
